dll_envelope_prep: RTL

Upstream feeder for the DLL truncation stage in the code-tracking loop.
- Takes one set of early/late integrate-and-dump correlator outputs.
- Forms approximate envelopes for early and late.
- Produces the 19-bit unsigned denominator (E+L), the 19-bit signed numerator (E−L), and the 5-bit MSB index of the denominator.
- Both downstream truncators use that index to normalise numerator and denominator to 11 bits.
- Multi-cycle, one result per start, start/busy/done handshake.

---
 rtl/dll_envelope_prep_if.sv | 28 ++
 rtl/dll_envelope_prep.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dll_envelope_prep_if.sv
// Handshake and data bundle between a correlator-dump source and dll_envelope_prep.
// The slave modport is the envelope-prep side; the master modport is the requester.
interface dll_envelope_prep_if #(
   parameter int unsigned INPUT_WIDTH = 18,
   parameter int unsigned SUM_WIDTH   = 19,
   parameter int unsigned INDEX_WIDTH = 5
);
   logic                   start;
   logic [INPUT_WIDTH-1:0] i_early;
   logic [INPUT_WIDTH-1:0] q_early;
   logic [INPUT_WIDTH-1:0] i_late;
   logic [INPUT_WIDTH-1:0] q_late;
   logic                   busy;
   logic                   done;
   logic [SUM_WIDTH-1:0]   sum_out;
   logic [SUM_WIDTH-1:0]   diff_out;
   logic [INDEX_WIDTH-1:0] index_out;

   modport master (
      output start, i_early, q_early, i_late, q_late,
      input  busy, done, sum_out, diff_out, index_out
   );

   modport slave (
      input  start, i_early, q_early, i_late, q_late,
      output busy, done, sum_out, diff_out, index_out
   );
endinterface

// File: rtl/dll_envelope_prep.sv
// Early/late envelope approximation (max + min/2) feeding the DLL truncators: produces
// E+L, E-L and the MSB index of E+L (clamped at MIN_INDEX) over a multi-cycle sequence.
module dll_envelope_prep #(
   parameter int unsigned INPUT_WIDTH = 18,
   parameter int unsigned SUM_WIDTH   = 19,
   parameter int unsigned INDEX_WIDTH = 5,
   parameter int unsigned MIN_INDEX   = 10
) (
   input logic                clk,
   input logic                reset,
   dll_envelope_prep_if.slave bus_io
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StAbs  = 3'd1;
   localparam logic [2:0] StMagE = 3'd2;
   localparam logic [2:0] StMagL = 3'd3;
   localparam logic [2:0] StComb = 3'd4;
   localparam logic [2:0] StScan = 3'd5;
   localparam logic [2:0] StDone = 3'd6;

   localparam logic [INDEX_WIDTH-1:0] MinIdx = INDEX_WIDTH'(MIN_INDEX);
   localparam logic [INDEX_WIDTH-1:0] TopIdx = INDEX_WIDTH'(SUM_WIDTH - 1);

   logic [2:0]             state_q, state_d;
   logic [INPUT_WIDTH-1:0] ie_q, qe_q, il_q, ql_q;
   logic [INPUT_WIDTH-1:0] abs_ie_q, abs_qe_q, abs_il_q, abs_ql_q;
   logic [INPUT_WIDTH-1:0] mag_e_q, mag_l_q;
   logic [SUM_WIDTH-1:0]   sum_q, diff_q;
   logic [INDEX_WIDTH-1:0] k_q;
   logic                   busy_q, done_q;
   logic [SUM_WIDTH-1:0]   sum_out_q, diff_out_q;
   logic [INDEX_WIDTH-1:0] index_out_q;
   logic                   scan_hit;

   // Two's complement magnitude; the most negative input maps to 2^(W-1), which still fits.
   function automatic logic [INPUT_WIDTH-1:0] abs_val(input logic [INPUT_WIDTH-1:0] x);
      return x[INPUT_WIDTH-1] ? (~x + INPUT_WIDTH'(1)) : x;
   endfunction

   function automatic logic [INPUT_WIDTH-1:0] env_mag(input logic [INPUT_WIDTH-1:0] a,
                                                      input logic [INPUT_WIDTH-1:0] b);
      logic [INPUT_WIDTH-1:0] hi, lo;
      hi = (a > b) ? a : b;
      lo = (a > b) ? b : a;
      return hi + (lo >> 1);
   endfunction

   assign scan_hit = sum_q[k_q] || (k_q == MinIdx);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (bus_io.start) state_d = StAbs;
         StAbs:   state_d = StMagE;
         StMagE:  state_d = StMagL;
         StMagL:  state_d = StComb;
         StComb:  state_d = StScan;
         StScan:  if (scan_hit) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         ie_q        <= '0;
         qe_q        <= '0;
         il_q        <= '0;
         ql_q        <= '0;
         abs_ie_q    <= '0;
         abs_qe_q    <= '0;
         abs_il_q    <= '0;
         abs_ql_q    <= '0;
         mag_e_q     <= '0;
         mag_l_q     <= '0;
         sum_q       <= '0;
         diff_q      <= '0;
         k_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sum_out_q   <= '0;
         diff_out_q  <= '0;
         index_out_q <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != StIdle);
         done_q  <= (state_d == StDone);
         case (state_q)
            StIdle: begin
               if (bus_io.start) begin
                  ie_q <= bus_io.i_early;
                  qe_q <= bus_io.q_early;
                  il_q <= bus_io.i_late;
                  ql_q <= bus_io.q_late;
               end
            end
            StAbs: begin
               abs_ie_q <= abs_val(ie_q);
               abs_qe_q <= abs_val(qe_q);
               abs_il_q <= abs_val(il_q);
               abs_ql_q <= abs_val(ql_q);
            end
            StMagE: mag_e_q <= env_mag(abs_ie_q, abs_qe_q);
            StMagL: mag_l_q <= env_mag(abs_il_q, abs_ql_q);
            StComb: begin
               sum_q  <= SUM_WIDTH'(mag_e_q) + SUM_WIDTH'(mag_l_q);
               diff_q <= SUM_WIDTH'(mag_e_q) - SUM_WIDTH'(mag_l_q);
               k_q    <= TopIdx;
            end
            StScan: begin
               // Results are published only here, so outputs hold between done pulses.
               if (scan_hit) begin
                  sum_out_q   <= sum_q;
                  diff_out_q  <= diff_q;
                  index_out_q <= k_q;
               end else begin
                  k_q <= k_q - INDEX_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_io.busy      = busy_q;
   assign bus_io.done      = done_q;
   assign bus_io.sum_out   = sum_out_q;
   assign bus_io.diff_out  = diff_out_q;
   assign bus_io.index_out = index_out_q;

endmodule
